// File: rtl/rv_pkg.sv
// Shared register-file definitions used by the writeback scheduler and its arbiter.
package rv_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, wraps at N-1 -> 0, and grants the first active request.
module rr_arbiter #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);
    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_valid && req[idx]) begin
                gnt[idx]  = 1'b1;
                gnt_idx   = IW'(idx);
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port among writeback sources and tracks
// per-register busy bits so decode can detect RAW/WAW hazards.
module regfile_wb_scheduler
    import rv_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int NREG    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]      req_data,
    output logic                         rf_write,
    output logic [REG_ADDR_W-1:0]        rf_rd_addr,
    output logic [XLEN-1:0]              rf_rd,
    input  logic                         issue_valid,
    input  logic [REG_ADDR_W-1:0]        issue_rd,
    output logic                         issue_ready,
    input  logic [REG_ADDR_W-1:0]        rs1_addr,
    input  logic [REG_ADDR_W-1:0]        rs2_addr,
    output logic                         raw_hazard
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    logic [NREG-1:0]    busy_reg, busy_next;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      gnt_idx;
    logic               arb_valid;
    logic               gnt_valid;
    reg_addr_t          addr_arr [NUM_REQ];
    logic [XLEN-1:0]    data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi] = req_addr[REG_ADDR_W*gi +: REG_ADDR_W];
            assign data_arr[gi] = req_data[XLEN*gi +: XLEN];
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .gnt       (arb_gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (arb_valid)
    );

    // Reset dominates: no handshake and no write may complete while rst is high.
    assign gnt_valid  = arb_valid & ~rst;
    assign req_ready  = gnt_valid ? arb_gnt : '0;
    assign rf_rd_addr = gnt_valid ? addr_arr[gnt_idx] : '0;
    assign rf_rd      = gnt_valid ? data_arr[gnt_idx] : '0;
    assign rf_write   = gnt_valid & (rf_rd_addr != '0);

    assign issue_ready = rst | (issue_rd == '0) | ~busy_reg[issue_rd];
    assign raw_hazard  = ~rst & (((rs1_addr != '0) & busy_reg[rs1_addr]) |
                                 ((rs2_addr != '0) & busy_reg[rs2_addr]));

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (gnt_valid)
            rr_ptr_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : IW'(gnt_idx + 1'b1);
    end

    // Clear first so a same-cycle issue to the register being written leaves it busy.
    always_comb begin
        busy_next = busy_reg;
        if (rf_write)
            busy_next[rf_rd_addr] = 1'b0;
        if (issue_valid && issue_ready && issue_rd != '0)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            busy_reg   <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            busy_reg   <= busy_next;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler with a cycle-level behavioural model.
module tb_regfile_wb_scheduler;
    localparam int N  = 3;
    localparam int XL = 32;
    localparam int NR = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*5-1:0]    req_addr;
    logic [N*XL-1:0]   req_data;
    logic              rf_write;
    logic [4:0]        rf_rd_addr;
    logic [XL-1:0]     rf_rd;
    logic              issue_valid;
    logic [4:0]        issue_rd;
    logic              issue_ready;
    logic [4:0]        rs1_addr, rs2_addr;
    logic              raw_hazard;

    int checks = 0;
    int fails  = 0;

    regfile_wb_scheduler #(.NUM_REQ(N), .XLEN(XL), .NREG(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rf_write(rf_write), .rf_rd_addr(rf_rd_addr), .rf_rd(rf_rd),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .raw_hazard(raw_hazard)
    );

    always #5 clk = ~clk;

    // Model state: busy set, fairness pointer and register contents.
    bit            m_busy [NR];
    int            m_ptr;
    logic [XL-1:0] m_regs [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (rst) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        int            w;
        logic [N-1:0]  er;
        logic [4:0]    ea;
        logic [XL-1:0] ed;
        logic          ei, eh;
        w  = m_winner();
        er = '0;
        ea = '0;
        ed = '0;
        if (w >= 0) begin
            er[w] = 1'b1;
            ea = req_addr[5*w +: 5];
            ed = req_data[XL*w +: XL];
        end
        ei = rst || issue_rd == 0 || !m_busy[issue_rd];
        eh = !rst && ((rs1_addr != 0 && m_busy[rs1_addr]) || (rs2_addr != 0 && m_busy[rs2_addr]));
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rf_write", 64'(rf_write), 64'((w >= 0) && ea != 0));
        chk("rf_rd_addr", 64'(rf_rd_addr), 64'(ea));
        chk("rf_rd", 64'(rf_rd), 64'(ed));
        chk("issue_ready", 64'(issue_ready), 64'(ei));
        chk("raw_hazard", 64'(raw_hazard), 64'(eh));
    end

    always @(posedge clk) begin
        int         w;
        logic [4:0] a;
        bit         iss;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 0;
            m_ptr = 0;
        end else begin
            w   = m_winner();
            iss = issue_valid && issue_rd != 0 && !m_busy[issue_rd];
            if (w >= 0) begin
                a = req_addr[5*w +: 5];
                if (a != 0) begin
                    m_regs[a] = req_data[XL*w +: XL];
                    m_busy[a] = 0;
                end
                m_ptr = (w + 1) % N;
            end
            if (iss) m_busy[issue_rd] = 1;
        end
    end

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [XL-1:0] d);
        req_valid[i]          = v;
        req_addr[5*i +: 5]    = a;
        req_data[XL*i +: XL]  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [XL-1:0] dv [N];
        dv[0] = 32'h1111_0000; dv[1] = 32'h2222_0001; dv[2] = 32'h3333_0002;
        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), dv[i]);

        // Reset with every requester valid
        repeat (2) begin
            probe();
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_rf_write", 64'(rf_write), 64'(0));
            chk("rst_issue_ready", 64'(issue_ready), 64'(1));
        end
        step();
        rst = 1'b0;

        // Round robin with all three valid
        for (int i = 0; i < 4; i++) begin
            probe();
            chk("rr_grant", 64'(req_ready), 64'(3'b001 << (i % 3)));
            chk("rr_addr", 64'(rf_rd_addr), 64'((i % 3) + 1));
            chk("rr_data", 64'(rf_rd), 64'(dv[i % 3]));
        end
        step();
        req_valid = '0;

        // Scoreboard: issue x5, then writeback from req1
        issue_valid = 1'b1; issue_rd = 5'd5;
        step();
        issue_valid = 1'b0; rs1_addr = 5'd5;
        probe();
        chk("sb_raw_set", 64'(raw_hazard), 64'(1));
        chk("sb_waw_stall", 64'(issue_ready), 64'(0));
        step();
        set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        probe();
        chk("sb_wb_grant", 64'(req_ready), 64'(3'b010));
        chk("sb_wb_write", 64'(rf_write), 64'(1));
        chk("sb_wb_data", 64'(rf_rd), 64'(32'hDEAD_BEEF));
        step();
        req_valid = '0;
        probe();
        chk("sb_raw_clear", 64'(raw_hazard), 64'(0));
        chk("sb_issue_free", 64'(issue_ready), 64'(1));
        chk("sb_reg_value", 64'(m_regs[5]), 64'(32'hDEAD_BEEF));

        // Wrap: pointer at 2, only req0 and req2 valid
        step();
        set_req(0, 1'b1, 5'd6, 32'hA0A0_0006);
        set_req(2, 1'b1, 5'd7, 32'hC2C2_0007);
        probe();
        chk("wrap_first", 64'(req_ready), 64'(3'b100));
        step();
        req_valid[2] = 1'b0;
        probe();
        chk("wrap_second", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0;

        // x0: issue to x0 and a writeback to x0
        issue_valid = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
        probe();
        chk("x0_issue_ready", 64'(issue_ready), 64'(1));
        step();
        issue_valid = 1'b0;
        set_req(0, 1'b1, 5'd0, 32'h0000_1234);
        probe();
        chk("x0_grant", 64'(req_ready), 64'(3'b001));
        chk("x0_no_write", 64'(rf_write), 64'(0));
        step();
        req_valid = '0;

        // Reset mid-operation with x3/x7 busy and a request pending
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_rd = 5'd7;
        step();
        issue_valid = 1'b0; rs1_addr = 5'd3; rs2_addr = 5'd7;
        probe();
        chk("mid_raw_busy", 64'(raw_hazard), 64'(1));
        step();
        rst = 1'b1;
        set_req(1, 1'b1, 5'd9, 32'h9999_0009);
        probe();
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), dv[i]);
        probe();
        chk("mid_raw_clear", 64'(raw_hazard), 64'(0));
        chk("mid_ptr_zero", 64'(req_ready), 64'(3'b001));
        step();
        req_valid = '0; rs1_addr = '0; rs2_addr = '0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
